mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Sequences the shared 32x32 signed bit-pair multiplier (combinational, treated as a multicycle path)
//  and arbitrates it between two requesters (A: control-unit MUL op, B: secondary/auxiliary unit).
//  Latches operands, holds them stable MUL_CYCLES cycles, captures the 64-bit product into HI/LO.
//  Sits between the control unit and the multiplier datapath; HI/LO feed the register-file bus mux.
// PARAMETERS
//  WIDTH       32  operand width; product is 2*WIDTH
//  MUL_CYCLES  4   cycles operands are held before capture (>=1); covers multiplier settling
// PORTS
//  clk          in   1        system clock, rising edge
//  clr          in   1        asynchronous, active-low reset
//  a_valid      in   1        requester A has operands
//  a_ready      out  1        A granted; handshake = a_valid & a_ready
//  a_m, a_q     in   WIDTH    A multiplicand / multiplier (signed)
//  b_valid      in   1        requester B has operands
//  b_ready      out  1        B granted; handshake = b_valid & b_ready
//  b_m, b_q     in   WIDTH    B multiplicand / multiplier (signed)
//  abort        in   1        cancel in-flight multiply (synchronous)
//  mul_m, mul_q out  WIDTH    registered operands driven to multiplier
//  mul_out      in   2*WIDTH  product from multiplier
//  hi, lo       out  WIDTH    captured product [2W-1:W], [W-1:0]
//  a_done       out  1        1-cycle pulse: A result valid on hi/lo
//  b_done       out  1        1-cycle pulse: B result valid on hi/lo
//  busy         out  1        high in any state except IDLE
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE; mul_m, mul_q, hi, lo, cnt=0; a_done, b_done, busy=0;
//    last_grant=B (so A wins the first contention).
//  States: IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: readies combinational; only in IDLE, at most one high:
//    one valid -> that one gets ready; both valid -> the one != last_grant.
//    Handshake edge: mul_m/mul_q <= granted operands, owner <= winner, last_grant <= winner,
//    cnt <= MUL_CYCLES-1, -> WAIT. Valid dropped before handshake: no effect, no state kept.
//  WAIT: a_ready=b_ready=0; mul_m/mul_q held constant.
//    abort=1 -> IDLE; no done, hi/lo unchanged (abort has priority over capture).
//    else cnt==0 -> {hi,lo} <= mul_out, pulse owner's done, -> DONE; else cnt <= cnt-1.
//  DONE: owner's done=1 this cycle only; readies 0; unconditionally -> IDLE.
//    New handshake possible in the IDLE cycle that follows (one idle cycle between jobs).
//  Latency: handshake at edge E0 -> capture at edge E(MUL_CYCLES) -> done high the following cycle.
//  abort in IDLE/DONE ignored. hi/lo hold last captured value until next capture.
//  Arithmetic: product is two's-complement 2*WIDTH, passed through unmodified; no saturation.
//  mul_m/mul_q keep last operands after completion/abort (not cleared).
//  clr mid-operation: immediate return to reset values; in-flight result discarded, no done.
// TESTING
//  1. A: m=7, q=0xFFFFFFFD, MUL_CYCLES=4 -> a_ready same cycle; a_done 1 cycle, 5th cycle after
//     handshake edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high WAIT..DONE.
//  2. A and B held valid continuously from reset (A:5*6, B:-1*-1) -> grants A,B,A,B...; A job
//     hi=0 lo=30 with a_done only; B job hi=0 lo=1 with b_done only; readies never both high.
//  3. A: m=q=0x80000000 -> hi=0x40000000, lo=0; m=0x7FFFFFFF,q=0x80000000 -> hi=0xC0000000, lo=0x80000000.
//  4. Complete job (lo=30), then new job with abort=1 on 2nd WAIT cycle -> no done, hi/lo still
//     0/30, IDLE next cycle, a_ready available immediately.
//  5. clr low during WAIT -> outputs/registers 0 asynchronously (before next edge); after release
//     with both valid, A granted first.
//  6. MUL_CYCLES=1: handshake at E0, capture at E1, done high cycle after E1; back-to-back jobs
//     spaced exactly 3 cycles handshake-to-handshake.

Source files
------------

// File: rtl/mult_sequencer.sv
// Arbitrates two requesters onto one shared combinational multiplier and captures the product.
// Operands are held stable for MUL_CYCLES cycles so the multiplier output has settled at capture.
module mult_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [WIDTH-1:0]   a_m,
  input  logic [WIDTH-1:0]   a_q,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [WIDTH-1:0]   b_m,
  input  logic [WIDTH-1:0]   b_q,
  input  logic               abort,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  input  logic [2*WIDTH-1:0] mul_out,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               a_done,
  output logic               b_done,
  output logic               busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner_b;
  logic             last_grant_b;
  logic             capture;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant goes to the requester that did not win last time when both are valid.
  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        a_ready = a_valid && (!b_valid || last_grant_b);
        b_ready = b_valid && !a_ready;
        if (a_ready || b_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mul_m        <= '0;
      mul_q        <= '0;
      cnt          <= '0;
      owner_b      <= 1'b0;
      last_grant_b <= 1'b1;
    end else if (a_ready) begin
      mul_m        <= a_m;
      mul_q        <= a_q;
      cnt          <= CNT_LOAD;
      owner_b      <= 1'b0;
      last_grant_b <= 1'b0;
    end else if (b_ready) begin
      mul_m        <= b_m;
      mul_q        <= b_q;
      cnt          <= CNT_LOAD;
      owner_b      <= 1'b1;
      last_grant_b <= 1'b1;
    end else if (state == WAIT && !abort && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // hi/lo only change on a completed, non-aborted multiply.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi <= '0;
      lo <= '0;
    end else if (capture) begin
      hi <= mul_out[2*WIDTH-1:WIDTH];
      lo <= mul_out[WIDTH-1:0];
    end
  end

  assign busy   = (state != IDLE);
  assign a_done = (state == DONE) && !owner_b;
  assign b_done = (state == DONE) && owner_b;

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized and directed checks of mult_sequencer against a job-timing reference model.
// A second instance with MUL_CYCLES=1 checks the minimum back-to-back spacing.
module tb_mult_sequencer;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, abort = 1'b0;
  logic [31:0] a_m = '0, a_q = '0, b_m = '0, b_q = '0;
  logic        a_ready, b_ready, a_done, b_done, busy;
  logic [31:0] mul_m, mul_q, hi, lo;
  logic [63:0] mul_out;

  logic        a_ready_1, b_ready_1, a_done_1, b_done_1, busy_1;
  logic [31:0] mul_m_1, mul_q_1, hi_1, lo_1;
  logic [63:0] mul_out_1;

  int total = 0;
  int bad   = 0;

  // Reference model: job age in cycles since the handshake edge (0 = no job).
  int          age;
  logic        own_a, last_b;
  logic [31:0] exp_m, exp_q;
  logic [63:0] exp_hilo;

  logic        s_a_ready, s1_a_ready, s1_a_done;
  logic [63:0] s1_hilo;

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] sm, sq;
    sm = {{32{m[31]}}, m};
    sq = {{32{q[31]}}, q};
    return sm * sq;
  endfunction

  assign mul_out   = prod(mul_m, mul_q);
  assign mul_out_1 = prod(mul_m_1, mul_q_1);

  mult_sequencer #(.WIDTH(32), .MUL_CYCLES(M)) dut (
    .clk(clk), .clr(clr),
    .a_valid(a_valid), .a_ready(a_ready), .a_m(a_m), .a_q(a_q),
    .b_valid(b_valid), .b_ready(b_ready), .b_m(b_m), .b_q(b_q),
    .abort(abort), .mul_m(mul_m), .mul_q(mul_q), .mul_out(mul_out),
    .hi(hi), .lo(lo), .a_done(a_done), .b_done(b_done), .busy(busy)
  );

  mult_sequencer #(.WIDTH(32), .MUL_CYCLES(1)) dut_1 (
    .clk(clk), .clr(clr),
    .a_valid(a_valid), .a_ready(a_ready_1), .a_m(a_m), .a_q(a_q),
    .b_valid(b_valid), .b_ready(b_ready_1), .b_m(b_m), .b_q(b_q),
    .abort(abort), .mul_m(mul_m_1), .mul_q(mul_q_1), .mul_out(mul_out_1),
    .hi(hi_1), .lo(lo_1), .a_done(a_done_1), .b_done(b_done_1), .busy(busy_1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    age      = 0;
    own_a    = 1'b1;
    last_b   = 1'b1;
    exp_m    = '0;
    exp_q    = '0;
    exp_hilo = '0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model across the edge.
  task automatic applyStimulus(input logic av, input logic [31:0] am, input logic [31:0] aq,
                               input logic bv, input logic [31:0] bm, input logic [31:0] bq,
                               input logic ab);
    logic ea, eb, dn;
    @(negedge clk);
    a_valid = av; a_m = am; a_q = aq;
    b_valid = bv; b_m = bm; b_q = bq;
    abort   = ab;
    #1;
    ea = 1'b0;
    eb = 1'b0;
    if (age == 0) begin
      if (av && (!bv || last_b)) ea = 1'b1;
      else if (bv)               eb = 1'b1;
    end
    dn = (age == M + 1);
    checkOutput("ctl", 64'({a_ready, b_ready, busy, a_done, b_done}),
                64'({ea, eb, age != 0, dn && own_a, dn && !own_a}));
    checkOutput("hilo", {hi, lo}, exp_hilo);
    checkOutput("operands", {mul_m, mul_q}, {exp_m, exp_q});
    s_a_ready  = a_ready;
    s1_a_ready = a_ready_1;
    s1_a_done  = a_done_1;
    s1_hilo    = {hi_1, lo_1};
    if (age == 0) begin
      if (ea) begin
        own_a = 1'b1; last_b = 1'b0; exp_m = am; exp_q = aq; age = 1;
      end else if (eb) begin
        own_a = 1'b0; last_b = 1'b1; exp_m = bm; exp_q = bq; age = 1;
      end
    end else if (age <= M) begin
      if (ab) begin
        age = 0;
      end else if (age == M) begin
        exp_hilo = prod(exp_m, exp_q);
        age      = M + 1;
      end else begin
        age++;
      end
    end else begin
      age = 0;
    end
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic runJobA(input logic [31:0] m, input logic [31:0] q);
    applyStimulus(1'b1, m, q, 1'b0, '0, '0, 1'b0);
    idleCycles(M + 1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; abort = 1'b0;
    clr = 1'b0;
    #1;
    checkOutput("rst_ctl", 64'({a_ready, b_ready, busy, a_done, b_done}), 64'd0);
    checkOutput("rst_hilo", {hi, lo}, 64'd0);
    checkOutput("rst_operands", {mul_m, mul_q}, 64'd0);
    modelReset();
    @(negedge clk);
    clr = 1'b1;
  endtask

  function automatic logic [31:0] randOp();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    modelReset();
    #12;
    pulseReset();

    // Single A job with a negative multiplier.
    runJobA(32'd7, 32'hFFFF_FFFD);
    checkOutput("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Most-negative operand corners.
    runJobA(32'h8000_0000, 32'h8000_0000);
    checkOutput("t3_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
    runJobA(32'h7FFF_FFFF, 32'h8000_0000);
    checkOutput("t3_maxmin", {hi, lo}, 64'hC000_0000_8000_0000);

    // Both requesters held valid from reset: grants alternate starting with A.
    pulseReset();
    for (int i = 0; i < 4 * (M + 2); i++)
      applyStimulus(1'b1, 32'd5, 32'd6, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idleCycles(M + 2);

    // Completed job, then a job aborted on its second WAIT cycle.
    runJobA(32'd5, 32'd6);
    checkOutput("t4_first", {hi, lo}, 64'd30);
    applyStimulus(1'b1, 32'd5, 32'd7, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 32'd3, 32'd3, 1'b0, '0, '0, 1'b0);
    checkOutput("t4_ready_after_abort", 64'(s_a_ready), 64'd1);
    checkOutput("t4_hilo_kept", {hi, lo}, 64'd30);
    idleCycles(M + 1);

    // Asynchronous reset during WAIT, then A wins first contention.
    runJobA(32'd9, 32'd9);
    applyStimulus(1'b0, '0, '0, 1'b1, 32'd2, 32'd3, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    pulseReset();
    applyStimulus(1'b1, 32'd4, 32'd4, 1'b1, 32'd8, 32'd8, 1'b0);
    checkOutput("t5_grant_a", 64'(s_a_ready), 64'd1);
    idleCycles(M + 1);

    // MUL_CYCLES=1 instance: A held valid gives handshakes every 3 cycles.
    pulseReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 32'd5, 32'd6, 1'b0, '0, '0, 1'b0);
      checkOutput($sformatf("t6_ready_%0d", i), 64'(s1_a_ready), 64'((i % 3) == 0));
      checkOutput($sformatf("t6_done_%0d", i), 64'(s1_a_done), 64'((i % 3) == 2));
      if ((i % 3) == 2) checkOutput("t6_hilo", s1_hilo, 64'd30);
    end
    idleCycles(M + 2);

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom_range(0, 2) != 0, randOp(), randOp(),
                    $urandom_range(0, 2) != 0, randOp(), randOp(),
                    $urandom_range(0, 7) == 0);
    idleCycles(M + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
